// File: rtl/rx_read_arbiter_if.sv
// Bundle of RX FIFO read-port and consumer-side signals for rx_read_arbiter.
// master: the arbiter; slave: the FIFO plus consumers around it.
interface rx_read_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 4
);
  localparam int unsigned IdW = $clog2(NUM_REQ);

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_rd_en;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic [IdW-1:0]        out_id;
  logic                  drop_pulse;

  modport master (
    input  fifo_empty, fifo_data, req, out_ready,
    output fifo_rd_en, out_data, out_valid, out_id, drop_pulse
  );

  modport slave (
    output fifo_empty, fifo_data, req, out_ready,
    input  fifo_rd_en, out_data, out_valid, out_id, drop_pulse
  );
endinterface

// File: rtl/rx_read_arbiter.sv
// Round-robin arbiter sharing one RX FIFO read port among NUM_REQ consumers, in bursts.
// Optional HOLD timeout with byte drop is enabled by defining RX_ARB_TIMEOUT_EN.
module rx_read_arbiter #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned BURST_MAX      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  rx_read_arbiter_if.master   bus
);

  localparam int unsigned IdW    = $clog2(NUM_REQ);
  localparam int unsigned BurstW = $clog2(BURST_MAX + 1);
  localparam logic [BurstW-1:0] BurstMax = BurstW'(BURST_MAX);
  localparam logic [IdW-1:0]    LastIdx  = IdW'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("rx_read_arbiter: NUM_REQ must be in 2..8");
  end
  if (BURST_MAX < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_limits
    $error("rx_read_arbiter: BURST_MAX and TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StRead, StWait, StHold} state_e;

  state_e                r_state, w_state_next;
  logic [IdW-1:0]        r_out_id, r_last, w_winner;
  logic [BurstW-1:0]     r_burst, w_burst_inc;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic                  w_grant, w_xfer, w_continue, w_timeout;

  // Round-robin search starting one past the last granted index.
  always_comb begin
    logic        found;
    int unsigned idx;
    found    = 1'b0;
    idx      = 0;
    w_winner = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(r_last) + i) % NUM_REQ;
      if (!found && bus.req[idx]) begin
        found    = 1'b1;
        w_winner = IdW'(idx);
      end
    end
  end

  assign w_grant     = (r_state == StIdle) && (|bus.req) && !bus.fifo_empty;
  assign w_xfer      = (r_state == StHold) && r_out_valid && bus.out_ready[r_out_id];
  assign w_burst_inc = r_burst + BurstW'(1);
  assign w_continue  = bus.req[r_out_id] && !bus.fifo_empty && (w_burst_inc < BurstMax);

`ifdef RX_ARB_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  logic [TmoW-1:0] r_tmo_cnt;
  logic            r_drop;

  // Counts completed HOLD cycles; restarts whenever the FSM leaves HOLD.
  assign w_timeout = (r_state == StHold) && !w_xfer && (r_tmo_cnt == TmoLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
      r_drop    <= 1'b0;
    end else begin
      r_drop <= w_timeout;
      if (r_state != StHold) begin
        r_tmo_cnt <= '0;
      end else if (!w_timeout) begin
        r_tmo_cnt <= r_tmo_cnt + TmoW'(1);
      end
    end
  end

  assign bus.drop_pulse = r_drop;
`else
  assign w_timeout      = 1'b0;
  assign bus.drop_pulse = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (w_grant) w_state_next = StRead;
      StRead: if (!bus.fifo_empty) w_state_next = StWait;
      StWait: w_state_next = StHold;
      StHold: begin
        if (w_xfer) begin
          w_state_next = w_continue ? StRead : StIdle;
        end else if (w_timeout) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    bus.fifo_rd_en = (r_state == StRead) && !bus.fifo_empty;
    bus.out_data   = r_out_data;
    bus.out_valid  = r_out_valid;
    bus.out_id     = r_out_id;
  end

  // Reset value of r_last makes index 0 the first winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_id    <= '0;
      r_last      <= LastIdx;
      r_burst     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_grant) begin
        r_out_id <= w_winner;
        r_burst  <= '0;
      end
      if (r_state == StWait) begin
        r_out_data  <= bus.fifo_data;
        r_out_valid <= 1'b1;
      end
      if (w_xfer) begin
        r_out_valid <= 1'b0;
        r_burst     <= w_burst_inc;
        if (!w_continue) begin
          r_last <= r_out_id;
        end
      end else if (w_timeout) begin
        r_out_valid <= 1'b0;
        r_last      <= r_out_id;
      end
    end
  end

endmodule

// File: tb/tb_rx_read_arbiter.sv
// Directed self-checking bench for rx_read_arbiter with a small FIFO model and transfer log.
module tb_rx_read_arbiter;
  localparam int unsigned DW = 8;
  localparam int unsigned NR = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  rx_read_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  rx_read_arbiter #(
    .DATA_WIDTH    (DW),
    .NUM_REQ       (NR),
    .BURST_MAX     (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [7:0] fifo_mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign bus.fifo_empty = (wr_ptr == rd_ptr);

  int         log_id   [64];
  logic [7:0] log_data [64];
  int         log_cyc  [64];
  int log_cnt = 0, cyc = 0, pop_cnt = 0, rd_empty_cnt = 0, drop_cnt = 0;
  int n_checks = 0, n_errors = 0;

  // FIFO read port model plus monitors for pops, drops and completed transfers.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.fifo_rd_en) begin
      pop_cnt <= pop_cnt + 1;
      if (bus.fifo_empty) begin
        rd_empty_cnt <= rd_empty_cnt + 1;
      end else begin
        bus.fifo_data <= fifo_mem[rd_ptr % 64];
        rd_ptr        <= rd_ptr + 1;
      end
    end
    if (bus.drop_pulse) drop_cnt <= drop_cnt + 1;
    if (bus.out_valid && bus.out_ready[bus.out_id]) begin
      log_id[log_cnt]   <= int'(bus.out_id);
      log_data[log_cnt] <= bus.out_data;
      log_cyc[log_cnt]  <= cyc;
      log_cnt           <= log_cnt + 1;
    end
  end

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr % 64] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_xfers(input string tag, input int target);
    int budget;
    budget = 200;
    while (log_cnt < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check(tag, log_cnt, target);
  endtask

  task automatic wait_valid(input string tag);
    int budget;
    budget = 50;
    while (!bus.out_valid && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check(tag, int'(bus.out_valid), 1);
  endtask

  task automatic check_log(input string tag, input int idx, input int id, input int data);
    check({tag, "_id"}, log_id[idx], id);
    check({tag, "_data"}, int'(log_data[idx]), data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, p0, budget;
    bus.req       = '0;
    bus.out_ready = '0;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_rd_en", int'(bus.fifo_rd_en), 0);
    check("rst_id", int'(bus.out_id), 0);
    check("rst_data", int'(bus.out_data), 0);
    check("rst_drop", int'(bus.drop_pulse), 0);
    repeat (2) @(negedge clk);

    // Two full bursts: consumer 0 then consumer 1
    for (int i = 0; i < 8; i++) push(8'hA1 + 8'(i));
    bus.req       = 4'b1111;
    bus.out_ready = 4'b1111;
    base          = log_cnt;
    rst_n         = 1'b1;
    wait_xfers("burst_xfers", base + 8);
    for (int i = 0; i < 8; i++) check_log("burst", base + i, (i < 4) ? 0 : 1, 'hA1 + i);
    bus.req = '0;

    // Single requester 2, two bytes, then FIFO runs dry
    base = log_cnt;
    push(8'h55);
    push(8'h66);
    bus.req = 4'b0100;
    wait_xfers("single_xfers", base + 2);
    check_log("single0", base, 2, 'h55);
    check_log("single1", base + 1, 2, 'h66);
    repeat (4) @(negedge clk);
    check("single_idle_valid", int'(bus.out_valid), 0);
    check("single_pops", pop_cnt, 10);
    check("single_rd_empty", rd_empty_cnt, 0);
    bus.req = '0;

    // Grant to 0 with only a foreign consumer ready
    base = log_cnt;
    p0   = pop_cnt;
    push(8'h11);
    bus.req       = 4'b0001;
    bus.out_ready = 4'b0010;
    wait_valid("stall_valid");
    check("stall_id", int'(bus.out_id), 0);
    check("stall_data", int'(bus.out_data), 'h11);
`ifdef RX_ARB_TIMEOUT_EN
    repeat (7) @(negedge clk);
    check("tmo_hold_valid", int'(bus.out_valid), 1);
    check("tmo_hold_drop", int'(bus.drop_pulse), 0);
    @(negedge clk);
    check("tmo_drop", int'(bus.drop_pulse), 1);
    check("tmo_valid_clr", int'(bus.out_valid), 0);
    @(negedge clk);
    check("tmo_drop_once", int'(bus.drop_pulse), 0);
`else
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_hold_valid", int'(bus.out_valid), 1);
      check("stall_hold_data", int'(bus.out_data), 'h11);
    end
    check("stall_no_pop", pop_cnt, p0 + 1);
    check("stall_no_drop", int'(bus.drop_pulse), 0);
    bus.out_ready = 4'b0001;
    wait_xfers("stall_release", base + 1);
    check_log("stall", base, 0, 'h11);
`endif
    bus.out_ready = 4'b1111;
    bus.req       = '0;
    repeat (2) @(negedge clk);

    // req[0] dropped during HOLD; byte still delivered, then index 2 wins
    base = log_cnt;
    for (int i = 0; i < 4; i++) push(8'h21 + 8'(i));
    bus.out_ready = '0;
    bus.req       = 4'b0001;
    wait_valid("drop_req_valid");
    check("drop_req_id", int'(bus.out_id), 0);
    bus.req       = 4'b0100;
    bus.out_ready = 4'b1111;
    wait_xfers("drop_req_xfers", base + 4);
    check_log("drop_req0", base, 0, 'h21);
    for (int i = 1; i < 4; i++) check_log("drop_req_next", base + i, 2, 'h21 + i);
    bus.req = '0;

    // Lone requester 3 is re-granted after one IDLE cycle; in-burst rate 3 cycles/byte
    base = log_cnt;
    for (int i = 0; i < 6; i++) push(8'hB0 + 8'(i));
    bus.req = 4'b1000;
    wait_xfers("lone_xfers", base + 6);
    for (int i = 0; i < 6; i++) check_log("lone", base + i, 3, 'hB0 + i);
    check("lone_rate", log_cyc[base + 1] - log_cyc[base], 3);
    check("lone_regrant_gap", log_cyc[base + 4] - log_cyc[base + 3], 4);
    bus.req = '0;

    // Pointer wraps from 3 back to 0
    base = log_cnt;
    push(8'h77);
    bus.req = 4'b0011;
    wait_xfers("wrap_xfers", base + 1);
    check_log("wrap", base, 0, 'h77);
    bus.req = '0;
    repeat (2) @(negedge clk);

    // Asynchronous reset while in WAIT
    push(8'h31);
    push(8'h32);
    bus.out_ready = '0;
    bus.req       = 4'b0001;
    budget        = 20;
    while (!bus.fifo_rd_en && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("arst_read_seen", int'(bus.fifo_rd_en), 1);
    p0 = pop_cnt + 1;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", int'(bus.out_valid), 0);
    check("arst_rd_en", int'(bus.fifo_rd_en), 0);
    check("arst_id", int'(bus.out_id), 0);
    check("arst_data", int'(bus.out_data), 0);
    check("arst_drop", int'(bus.drop_pulse), 0);
    bus.req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("arst_no_pop", pop_cnt, p0);
    check("arst_idle_valid", int'(bus.out_valid), 0);

    check("rd_when_empty", rd_empty_cnt, 0);
`ifdef RX_ARB_TIMEOUT_EN
    check("drop_total", drop_cnt, 1);
`else
    check("drop_total", drop_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rx_read_arbiter.md
RX_READ_ARBITER -- requirements
Module: rx_read_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, byte width of the RX FIFO read data.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of consumers sharing the RX FIFO read port (2..8).
REQ-003 SHALL have parameter BURST_MAX, default 4, maximum consecutive bytes granted to one consumer per grant.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, HOLD timeout length (used only under RX_ARB_TIMEOUT_EN).
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 fifo_empty  input  1  RX FIFO empty flag.
REQ-008 fifo_data  input  DATA_WIDTH  RX FIFO read data, valid the cycle after fifo_rd_en.
REQ-009 fifo_rd_en  output  1  one-cycle pop strobe to the RX FIFO.
REQ-010 req  input  NUM_REQ  per-consumer request, level.
REQ-011 out_ready  input  NUM_REQ  per-consumer byte accept.
REQ-012 out_data  output  DATA_WIDTH  byte presented to the granted consumer.
REQ-013 out_valid  output  1  out_data valid.
REQ-014 out_id  output  $clog2(NUM_REQ)  index of granted consumer.
REQ-015 drop_pulse  output  1  one-cycle pulse when a held byte is discarded.

Function
REQ-016 SHALL implement FSM states IDLE, READ, WAIT, HOLD.
REQ-017 IDLE: when |req and !fifo_empty, SHALL select winner by round-robin starting from the index after the last granted one, latch out_id, clear burst counter, go READ.
REQ-018 READ: SHALL assert fifo_rd_en for exactly one cycle, go WAIT; fifo_rd_en SHALL never assert while fifo_empty=1.
REQ-019 WAIT: SHALL capture fifo_data into out_data register, set out_valid, go HOLD.
REQ-020 HOLD: out_data/out_id SHALL remain stable while out_valid=1; transfer completes on a cycle with out_valid and out_ready[out_id] both 1; out_ready of other indices SHALL be ignored.
REQ-021 On transfer: burst counter increments; if req[out_id]=1, !fifo_empty and count<BURST_MAX, go READ (same consumer); else clear out_valid, update round-robin pointer to out_id, go IDLE.
REQ-022 Minimum throughput: one byte per 3 cycles within a burst (READ, WAIT, HOLD-with-ready).
REQ-023 Dropping req[out_id] during HOLD SHALL NOT cancel the held byte; burst ends after its transfer.
REQ-024 With only one requester active, it SHALL be re-granted after each burst with no idle gap beyond one IDLE cycle.
REQ-025 Round-robin pointer SHALL wrap from NUM_REQ-1 to 0.
REQ-026 Burst counter width SHALL hold BURST_MAX without overflow.

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE, fifo_rd_en=0, out_valid=0, out_data=0, out_id=0, drop_pulse=0, burst counter=0, round-robin pointer such that index 0 wins first.
REQ-028 Reset mid-burst SHALL discard any held byte without pulsing fifo_rd_en or drop_pulse.

Configuration
REQ-029 With macro RX_ARB_TIMEOUT_EN defined, a HOLD lasting TIMEOUT_CYCLES cycles without transfer SHALL clear out_valid, pulse drop_pulse one cycle, end the burst, advance the pointer, go IDLE.
REQ-030 Without RX_ARB_TIMEOUT_EN, HOLD SHALL wait indefinitely and drop_pulse SHALL be constant 0.

Verification
REQ-031 After reset, req=4'b1111, FIFO holds 0xA1..0xA8, out_ready all 1 -> consumer 0 receives 0xA1..0xA4, consumer 1 receives 0xA5..0xA8.
REQ-032 req=4'b0100, FIFO 2 bytes 0x55,0x66 -> out_id=2, two transfers, then IDLE with fifo_rd_en never asserted while fifo_empty=1.
REQ-033 Grant to 0, out_ready[1]=1 and out_ready[0]=0 for 10 cycles -> out_valid held, out_data stable, no pop.
REQ-034 req[0] dropped in HOLD with 3 bytes left in FIFO -> held byte delivered, next grant to next requesting index.
REQ-035 rst_n pulsed low asynchronously in WAIT -> outputs at reset values immediately, no further fifo_rd_en.
REQ-036 RX_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, out_ready=0 -> drop_pulse high for one cycle 8 cycles into HOLD, out_valid cleared.
